rename_commit_ctrl: RTL and testbench

In-order tag allocator and commit sequencer for the register file in the out-of-order core. It grants rename tags to the decoder and drives the register file's rename port. It captures completion broadcasts and drives the register file's commit port strictly in program order. It owns a 16-entry circular buffer of in-flight destinations and flushes it on `clear`.

---
 rtl/rename_commit_ctrl_pkg.sv | 24 ++
 rtl/rename_commit_ctrl_rob_ptr.sv | 24 ++
 rtl/rename_commit_ctrl.sv | 151 +++++++++++++++
 tb/tb_rename_commit_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rename_commit_ctrl_pkg.sv
// rtl/rename_commit_ctrl_pkg.sv - shared widths, constants and tag/index conversion
package rename_commit_ctrl_pkg;

  localparam int ROB_SIZE  = 16;
  localparam int ROB_IDX_W = 4;
  localparam int TAG_W     = 5;
  localparam int REG_W     = 5;
  localparam int DATA_W    = 32;

  localparam logic [TAG_W-1:0] EMPTY_TAG = '0;
  localparam logic [REG_W-1:0] EMPTY_REG = '0;

  // Tag 0 is reserved for "no producer", so tags are offset by one from indices.
  function automatic logic [TAG_W-1:0] idx_to_tag(input logic [ROB_IDX_W-1:0] idx);
    return {1'b0, idx} + TAG_W'(1);
  endfunction

  function automatic logic [ROB_IDX_W-1:0] tag_to_idx(input logic [TAG_W-1:0] tag);
    logic [TAG_W-1:0] w_t;
    w_t = tag - TAG_W'(1);
    return w_t[ROB_IDX_W-1:0];
  endfunction

endpackage

// File: rtl/rename_commit_ctrl_rob_ptr.sv
// rtl/rename_commit_ctrl_rob_ptr.sv - modulo-ROB_SIZE pointer with enable and sync clear
module rob_ptr
  import rename_commit_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 i_clr,
  input  logic                 i_en,
  output logic [ROB_IDX_W-1:0] o_ptr
);

  logic [ROB_IDX_W-1:0] r_ptr;

  // Advance by one on enable, wrapping at the last entry; clear has priority.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_ptr <= '0;
    end else if (i_en) begin
      r_ptr <= (r_ptr == ROB_IDX_W'(ROB_SIZE - 1)) ? '0 : r_ptr + ROB_IDX_W'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/rename_commit_ctrl.sv
// rtl/rename_commit_ctrl.sv - in-order rename tag allocator and commit sequencer
module rename_commit_ctrl
  import rename_commit_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              issue_valid,
  input  logic [REG_W-1:0]  issue_rd,
  output logic              issue_ready,
  output logic [TAG_W-1:0]  issue_tag,
  output logic [REG_W-1:0]  reg_to_rename,
  output logic [TAG_W-1:0]  tag_rename,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              if_commit,
  output logic [REG_W-1:0]  pos_commit,
  output logic [DATA_W-1:0] data_commit,
  output logic [TAG_W-1:0]  tag_commit,
  output logic              rob_empty
);

  logic                 r_busy [ROB_SIZE];
  logic                 r_done [ROB_SIZE];
  logic [REG_W-1:0]     r_rd   [ROB_SIZE];
  logic [DATA_W-1:0]    r_data [ROB_SIZE];
  logic [TAG_W-1:0]     r_count;
  logic                 r_if_commit;
  logic [REG_W-1:0]     r_pos_commit;
  logic [DATA_W-1:0]    r_data_commit;
  logic [TAG_W-1:0]     r_tag_commit;
  logic                 r_rob_empty;

  logic [ROB_IDX_W-1:0] w_head;
  logic [ROB_IDX_W-1:0] w_tail;
  logic [ROB_IDX_W-1:0] w_cdb_idx;
  logic                 w_ptr_clr;
  logic                 w_accept;
  logic                 w_retire;
  logic                 w_cdb_hit;
  logic                 w_rename;
  logic [TAG_W-1:0]     w_count_nxt;

  assign w_ptr_clr = rst || (rdy && clear);
  assign w_cdb_idx = tag_to_idx(cdb_tag);

  // Ready is judged on the pre-retire count: a slot freed this cycle is not reusable until next.
  assign issue_ready = (r_count < TAG_W'(ROB_SIZE));
  assign issue_tag   = idx_to_tag(w_tail);
  assign w_accept    = rdy && !rst && !clear && issue_valid && issue_ready;
  assign w_rename    = w_accept && (issue_rd != EMPTY_REG);
  assign reg_to_rename = w_rename ? issue_rd  : EMPTY_REG;
  assign tag_rename    = w_rename ? issue_tag : EMPTY_TAG;

  // Completion only lands on a live entry; retire looks at the registered done bit (no bypass).
  assign w_cdb_hit = rdy && !clear && cdb_valid && (cdb_tag != EMPTY_TAG) && r_busy[w_cdb_idx];
  assign w_retire  = rdy && !clear && (r_count != '0) && r_done[w_head];

  // Net occupancy change from this cycle's issue and retire.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_accept, w_retire})
      2'b10:   w_count_nxt = r_count + TAG_W'(1);
      2'b01:   w_count_nxt = r_count - TAG_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  rob_ptr u_head (
    .clk   (clk),
    .i_clr (w_ptr_clr),
    .i_en  (w_retire),
    .o_ptr (w_head)
  );

  rob_ptr u_tail (
    .clk   (clk),
    .i_clr (w_ptr_clr),
    .i_en  (w_accept),
    .o_ptr (w_tail)
  );

  // Per-entry state: allocate at tail, complete from CDB, free at head (retire wins on conflict).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        r_busy[i] <= 1'b0;
        r_done[i] <= 1'b0;
        r_rd[i]   <= '0;
        r_data[i] <= '0;
      end
    end else if (rdy) begin
      if (clear) begin
        for (int i = 0; i < ROB_SIZE; i++) begin
          r_busy[i] <= 1'b0;
          r_done[i] <= 1'b0;
        end
      end else begin
        if (w_cdb_hit) begin
          r_data[w_cdb_idx] <= cdb_data;
          r_done[w_cdb_idx] <= 1'b1;
        end
        if (w_accept) begin
          r_busy[w_tail] <= 1'b1;
          r_done[w_tail] <= 1'b0;
          r_rd[w_tail]   <= issue_rd;
        end
        if (w_retire) begin
          r_busy[w_head] <= 1'b0;
          r_done[w_head] <= 1'b0;
        end
      end
    end
  end

  // Occupancy and registered commit port; everything holds while rdy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count       <= '0;
      r_rob_empty   <= 1'b1;
      r_if_commit   <= 1'b0;
      r_pos_commit  <= '0;
      r_data_commit <= '0;
      r_tag_commit  <= '0;
    end else if (rdy) begin
      if (clear) begin
        r_count     <= '0;
        r_rob_empty <= 1'b1;
        r_if_commit <= 1'b0;
      end else begin
        r_count     <= w_count_nxt;
        r_rob_empty <= (w_count_nxt == '0);
        r_if_commit <= w_retire && (r_rd[w_head] != EMPTY_REG);
        if (w_retire) begin
          r_pos_commit  <= r_rd[w_head];
          r_data_commit <= r_data[w_head];
          r_tag_commit  <= idx_to_tag(w_head);
        end
      end
    end
  end

  assign if_commit   = r_if_commit;
  assign pos_commit  = r_pos_commit;
  assign data_commit = r_data_commit;
  assign tag_commit  = r_tag_commit;
  assign rob_empty   = r_rob_empty;

endmodule

// File: tb/tb_rename_commit_ctrl.sv
// tb/tb_rename_commit_ctrl.sv - directed self-checking bench for rename_commit_ctrl
module tb_rename_commit_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, clear;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [4:0]  issue_tag, reg_to_rename, tag_rename;
  logic        cdb_valid;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        if_commit;
  logic [4:0]  pos_commit, tag_commit;
  logic [31:0] data_commit;
  logic        rob_empty;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rename_commit_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .clear         (clear),
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .issue_ready   (issue_ready),
    .issue_tag     (issue_tag),
    .reg_to_rename (reg_to_rename),
    .tag_rename    (tag_rename),
    .cdb_valid     (cdb_valid),
    .cdb_tag       (cdb_tag),
    .cdb_data      (cdb_data),
    .if_commit     (if_commit),
    .pos_commit    (pos_commit),
    .data_commit   (data_commit),
    .tag_commit    (tag_commit),
    .rob_empty     (rob_empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rdy = 1'b1; clear = 1'b0;
    issue_valid = 1'b0; issue_rd = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1'b1; issue_rd = rd;
    tick();
    issue_valid = 1'b0; issue_rd = '0;
  endtask

  task automatic cdb(input logic [4:0] t, input logic [31:0] d);
    cdb_valid = 1'b1; cdb_tag = t; cdb_data = d;
    tick();
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_empty", 32'(rob_empty), 32'd1);
    chk("rst_commit", 32'(if_commit), 32'd0);
    chk("rst_tagc", 32'(tag_commit), 32'd0);
    chk("rst_ready", 32'(issue_ready), 32'd1);
    chk("rst_itag", 32'(issue_tag), 32'd1);
    chk("rst_tagren", 32'(tag_rename), 32'd0);

    // Single issue, complete, commit two edges after the CDB
    issue_valid = 1'b1; issue_rd = 5'd5; #1;
    chk("t1_itag", 32'(issue_tag), 32'd1);
    chk("t1_regren", 32'(reg_to_rename), 32'd5);
    chk("t1_tagren", 32'(tag_rename), 32'd1);
    tick();
    issue_valid = 1'b0; issue_rd = '0;
    chk("t1_notempty", 32'(rob_empty), 32'd0);
    cdb(5'd1, 32'hDEADBEEF);
    chk("t1_e1_commit", 32'(if_commit), 32'd0);
    tick();
    chk("t1_commit", 32'(if_commit), 32'd1);
    chk("t1_pos", 32'(pos_commit), 32'd5);
    chk("t1_data", data_commit, 32'hDEADBEEF);
    chk("t1_tagc", 32'(tag_commit), 32'd1);
    chk("t1_empty", 32'(rob_empty), 32'd1);
    tick();
    chk("t1_idle", 32'(if_commit), 32'd0);

    // Out-of-order completion, in-order commit
    do_reset();
    issue(5'd7); issue(5'd8); issue(5'd9);
    cdb(5'd3, 32'h33);
    chk("t2_nocommit3", 32'(if_commit), 32'd0);
    cdb(5'd1, 32'h11);
    chk("t2_nocommit1", 32'(if_commit), 32'd0);
    cdb(5'd2, 32'h22);
    chk("t2_c1", 32'(if_commit), 32'd1);
    chk("t2_c1_tag", 32'(tag_commit), 32'd1);
    chk("t2_c1_pos", 32'(pos_commit), 32'd7);
    chk("t2_c1_data", data_commit, 32'h11);
    tick();
    chk("t2_c2", 32'(if_commit), 32'd1);
    chk("t2_c2_tag", 32'(tag_commit), 32'd2);
    chk("t2_c2_data", data_commit, 32'h22);
    tick();
    chk("t2_c3", 32'(if_commit), 32'd1);
    chk("t2_c3_tag", 32'(tag_commit), 32'd3);
    chk("t2_c3_pos", 32'(pos_commit), 32'd9);
    chk("t2_c3_data", data_commit, 32'h33);
    chk("t2_empty", 32'(rob_empty), 32'd1);
    tick();
    chk("t2_idle", 32'(if_commit), 32'd0);

    // Fill to 16, full stall, retire one, wrap-around tag reuse
    do_reset();
    for (int i = 0; i < 16; i++) begin
      issue_valid = 1'b1; issue_rd = 5'(i + 1); #1;
      chk("t3_fill_tag", 32'(tag_rename), 32'(i + 1));
      tick();
    end
    issue_rd = 5'd20; #1;
    chk("t3_full_ready", 32'(issue_ready), 32'd0);
    chk("t3_full_tagren", 32'(tag_rename), 32'd0);
    chk("t3_full_regren", 32'(reg_to_rename), 32'd0);
    cdb(5'd1, 32'hA1);
    issue_valid = 1'b1; issue_rd = 5'd20; #1;
    chk("t3_retire_cycle_ready", 32'(issue_ready), 32'd0);
    tick();
    chk("t3_retire_commit", 32'(if_commit), 32'd1);
    chk("t3_retire_data", data_commit, 32'hA1);
    chk("t3_reopen_ready", 32'(issue_ready), 32'd1);
    chk("t3_reuse_tag", 32'(issue_tag), 32'd1);
    chk("t3_reuse_tagren", 32'(tag_rename), 32'd1);
    tick();
    issue_valid = 1'b0; issue_rd = '0; #1;
    chk("t3_refull_ready", 32'(issue_ready), 32'd0);
    cdb(5'd16, 32'h16);
    chk("t3_tag16_nocommit", 32'(if_commit), 32'd0);

    // rd = 0: no rename, no commit strobe, count still drops
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd0; #1;
    chk("t4_itag", 32'(issue_tag), 32'd1);
    chk("t4_tagren", 32'(tag_rename), 32'd0);
    chk("t4_regren", 32'(reg_to_rename), 32'd0);
    tick();
    issue_valid = 1'b0;
    chk("t4_notempty", 32'(rob_empty), 32'd0);
    cdb(5'd1, 32'h44);
    tick();
    chk("t4_commit", 32'(if_commit), 32'd0);
    chk("t4_empty", 32'(rob_empty), 32'd1);
    chk("t4_itag2", 32'(issue_tag), 32'd2);

    // clear flushes; stale CDB ignored
    do_reset();
    issue(5'd1); issue(5'd2); issue(5'd3); issue(5'd4);
    cdb(5'd1, 32'h1);
    cdb(5'd2, 32'h2);
    chk("t5_precommit", 32'(if_commit), 32'd1);
    clear = 1'b1; cdb_valid = 1'b1; cdb_tag = 5'd3; cdb_data = 32'h3;
    tick();
    clear = 1'b0; cdb_valid = 1'b0; #1;
    chk("t5_empty", 32'(rob_empty), 32'd1);
    chk("t5_commit", 32'(if_commit), 32'd0);
    chk("t5_itag", 32'(issue_tag), 32'd1);
    issue(5'd6);
    cdb(5'd3, 32'hBAD);
    tick();
    chk("t5_stale_commit", 32'(if_commit), 32'd0);
    chk("t5_stale_empty", 32'(rob_empty), 32'd0);

    // rdy low freezes a pending commit
    do_reset();
    issue(5'd9); issue(5'd10);
    cdb(5'd1, 32'h55);
    cdb(5'd2, 32'h66);
    chk("t6_c1", 32'(if_commit), 32'd1);
    chk("t6_c1_tag", 32'(tag_commit), 32'd1);
    rdy = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd12; #1;
    chk("t6_stall_tagren", 32'(tag_rename), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_hold_commit", 32'(if_commit), 32'd1);
      chk("t6_hold_tag", 32'(tag_commit), 32'd1);
      chk("t6_hold_data", data_commit, 32'h55);
      chk("t6_hold_empty", 32'(rob_empty), 32'd0);
    end
    issue_valid = 1'b0; issue_rd = '0;
    rdy = 1'b1;
    tick();
    chk("t6_c2", 32'(if_commit), 32'd1);
    chk("t6_c2_tag", 32'(tag_commit), 32'd2);
    chk("t6_c2_pos", 32'(pos_commit), 32'd10);
    chk("t6_c2_data", data_commit, 32'h66);
    chk("t6_empty", 32'(rob_empty), 32'd1);
    tick();
    chk("t6_idle", 32'(if_commit), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
